// File: rtl/l2_cacheline_adapter.sv
// l2_cacheline_adapter: converts single-cycle L2 line transfers into multi-beat memory bursts
module l2_cacheline_adapter #(
    parameter int s_line = 256,
    parameter int s_burst = 64,
    parameter int num_beats = s_line / s_burst
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [s_line-1:0]  line_i,
    output logic [s_line-1:0]  line_o,
    input  logic [31:0]        address_i,
    input  logic               read_i,
    input  logic               write_i,
    output logic               resp_o,
    input  logic [s_burst-1:0] burst_i,
    output logic [s_burst-1:0] burst_o,
    output logic [31:0]        address_o,
    output logic               read_o,
    output logic               write_o,
    input  logic               resp_i
);
    localparam int cw = $clog2(num_beats);
    localparam int ob = $clog2(s_line / 8);
    localparam logic [cw-1:0] last = cw'(num_beats - 1);

    typedef enum logic [1:0] {IDLE, READ, WRITE, DONE} state_t;

    state_t             state, state_n;
    logic [cw-1:0]      count;
    logic [31:0]        addr_q;
    logic [s_line-1:0]  wbuf, line_q;
    logic               accept, beat;

    assign accept    = state == IDLE && (read_i || write_i);
    assign beat      = (state == READ || state == WRITE) && resp_i;
    assign read_o    = state == READ;
    assign write_o   = state == WRITE;
    assign resp_o    = state == DONE;
    assign address_o = addr_q;
    assign line_o    = line_q;
    assign burst_o   = wbuf[count * s_burst +: s_burst];

    // state register; reset abandons any burst in flight
    always_ff @(posedge clk) begin
        if (!rst) state <= IDLE;
        else      state <= state_n;
    end

    // next state: write-back wins over fill, last strobed beat finishes the burst
    always_comb begin
        state_n = state;
        case (state)
            IDLE:    state_n = write_i ? WRITE : (read_i ? READ : IDLE);
            READ:    state_n = (resp_i && count == last) ? DONE : READ;
            WRITE:   state_n = (resp_i && count == last) ? DONE : WRITE;
            default: state_n = IDLE;
        endcase
    end

    // datapath: request capture, beat counter, fill assembly
    always_ff @(posedge clk) begin
        if (!rst) begin
            count  <= '0;
            addr_q <= '0;
            wbuf   <= '0;
            line_q <= '0;
        end else begin
            if (accept) begin
                addr_q <= {address_i[31:ob], {ob{1'b0}}};
                count  <= '0;
                if (write_i) wbuf <= line_i;
            end
            if (beat) count <= count + 1'b1;
            if (beat && state == READ) line_q[count * s_burst +: s_burst] <= burst_i;
        end
    end
endmodule

// File: tb/tb_l2_cacheline_adapter.sv
// tb_l2_cacheline_adapter: directed-vector check of the L2 line/burst adapter
module tb_l2_cacheline_adapter;
    logic         clk = 0;
    logic         rst;
    logic [255:0] line_i, line_o;
    logic [31:0]  address_i, address_o;
    logic         read_i, write_i, resp_o;
    logic [63:0]  burst_i, burst_o;
    logic         read_o, write_o, resp_i;

    int errors = 0;
    int checks = 0;

    logic [63:0]  a [4], d [4], e [4], b [4], c [4];
    logic [255:0] a_line, d_line, e_line, c_line;
    int           pat [7] = '{1, 0, 0, 1, 1, 0, 1};
    int           exp_idx [7] = '{0, 1, 1, 1, 2, 3, 3};

    l2_cacheline_adapter dut (
        .clk(clk), .rst(rst), .line_i(line_i), .line_o(line_o),
        .address_i(address_i), .read_i(read_i), .write_i(write_i), .resp_o(resp_o),
        .burst_i(burst_i), .burst_o(burst_o), .address_o(address_o),
        .read_o(read_o), .write_o(write_o), .resp_i(resp_i)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [255:0] got, input logic [255:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        for (int i = 0; i < 4; i++) begin
            a[i] = {8{8'hA0 + 8'(i)}};
            d[i] = {8{8'hD0 + 8'(i)}};
            e[i] = {8{8'hE0 + 8'(i)}};
            b[i] = {8{8'hB0 + 8'(i)}};
            c[i] = {8{8'hC0 + 8'(i)}};
        end
        a_line = {a[3], a[2], a[1], a[0]};
        d_line = {d[3], d[2], d[1], d[0]};
        e_line = {e[3], e[2], e[1], e[0]};
        c_line = {c[3], c[2], c[1], c[0]};

        rst = 0; read_i = 1; write_i = 0; resp_i = 0;
        line_i = '0; burst_i = '0; address_i = 32'h1234_5678;
        tick(); tick();
        chk("rst_resp", resp_o, 0);
        chk("rst_read", read_o, 0);
        chk("rst_write", write_o, 0);
        chk("rst_addr", address_o, 0);
        chk("rst_burst", burst_o, 0);
        chk("rst_line", line_o, 0);

        rst = 1;
        tick();
        chk("fill_read_o", read_o, 1);
        chk("fill_addr", address_o, 32'h1234_5660);
        for (int i = 0; i < 4; i++) begin
            chk("fill_noresp", resp_o, 0);
            resp_i = 1; burst_i = a[i];
            tick();
        end
        resp_i = 0;
        chk("fill_resp", resp_o, 1);
        chk("fill_read_low", read_o, 0);
        chk("fill_line", line_o, a_line);
        read_i = 0;
        tick();
        chk("fill_resp_once", resp_o, 0);

        line_i = d_line; address_i = 32'h8000_001F; write_i = 1;
        tick();
        chk("wb_write_o", write_o, 1);
        chk("wb_addr", address_o, 32'h8000_0000);
        for (int i = 0; i < 7; i++) begin
            chk("wb_burst", burst_o, d[exp_idx[i]]);
            chk("wb_noread", read_o, 0);
            chk("wb_noresp", resp_o, 0);
            resp_i = pat[i][0];
            tick();
        end
        resp_i = 0;
        chk("wb_resp", resp_o, 1);
        chk("wb_write_low", write_o, 0);
        chk("wb_line_kept", line_o, a_line);
        write_i = 0;
        tick();

        line_i = e_line; address_i = 32'h0000_1000; read_i = 1; write_i = 1;
        tick();
        chk("both_write_o", write_o, 1);
        for (int i = 0; i < 4; i++) begin
            chk("both_noread", read_o, 0);
            chk("both_burst", burst_o, e[i]);
            resp_i = 1;
            tick();
        end
        chk("both_resp", resp_o, 1);
        chk("both_line_kept", line_o, a_line);
        read_i = 0; write_i = 0;
        tick();
        tick();
        chk("idle_spurious", read_o | write_o | resp_o, 0);
        resp_i = 0;

        address_i = 32'h0000_0040; read_i = 1;
        tick();
        resp_i = 1; burst_i = b[0];
        tick();
        chk("beat0_slot", line_o[63:0], b[0]);
        burst_i = b[1];
        tick();
        resp_i = 0; rst = 0;
        tick();
        chk("midrst_read", read_o, 0);
        chk("midrst_line", line_o, 0);
        chk("midrst_addr", address_o, 0);
        rst = 1; address_i = 32'h0000_0080;
        tick();
        chk("refill_read_o", read_o, 1);
        chk("refill_addr", address_o, 32'h0000_0080);
        for (int i = 0; i < 4; i++) begin
            resp_i = 1; burst_i = c[i];
            tick();
        end
        resp_i = 0;
        chk("refill_resp", resp_o, 1);
        chk("refill_line", line_o, c_line);
        read_i = 0;
        tick();
        chk("refill_idle", resp_o | read_o, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
